pl_kernel_hls_deadlock_report_unit: RTL and testbench
=====================================================

PL_KERNEL_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: pl_kernel_hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4, meaning the number of per-process detect units feeding this block.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive cycles of nonzero detect needed to confirm a deadlock (legal range 1..255).
REQ-003 SHALL have parameter TRACE_TIMEOUT, default 1024, meaning the maximum trace cycles before abort (legal range 2..65535).
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port dl_detect_vec, input, PROC_NUM, with bit p being dl_detect_out of process p's detect unit.
REQ-007 SHALL have port report_ack, input, 1, a host acknowledge that releases the report.
REQ-008 SHALL have port dl_detect_in, output, 1, broadcast to all detect units while tracing and reporting.
REQ-009 SHALL have port origin_vec, output, PROC_NUM, a one-hot token-launch pulse to the selected process.
REQ-010 SHALL have port token_clear, output, 1, a single-cycle pulse broadcast to all units when the trace closes.
REQ-011 SHALL have port deadlock_detected, output, 1, a sticky report-valid flag.
REQ-012 SHALL have port deadlock_proc_id, output, max(1,$clog2(PROC_NUM)), the origin process index.
REQ-013 SHALL have port deadlock_trace_mask, output, PROC_NUM, the processes visited by the token.
REQ-014 SHALL have port trace_len, output, 16, the number of cycles from launch to closure.
REQ-015 SHALL have port trace_timeout, output, 1, set when the trace aborted on TRACE_TIMEOUT.

Function
REQ-016 SHALL implement the FSM states IDLE, DEBOUNCE, LAUNCH, TRACE and REPORT.
REQ-017 In IDLE, |dl_detect_vec SHALL move the FSM to DEBOUNCE with the debounce counter set to 1.
REQ-018 In DEBOUNCE, while |dl_detect_vec the counter SHALL increment.
REQ-019 In DEBOUNCE, when the counter reaches DEBOUNCE_CYCLES the FSM SHALL go to LAUNCH and latch sel_id as the lowest-index set bit of that cycle's dl_detect_vec.
REQ-020 In DEBOUNCE, dl_detect_vec==0 SHALL return the FSM to IDLE and clear the counter.
REQ-021 With DEBOUNCE_CYCLES=1, the IDLE->DEBOUNCE entry cycle SHALL count as satisfied and the next state SHALL be LAUNCH directly.
REQ-022 In LAUNCH, which lasts exactly one cycle, origin_vec SHALL be 1<<sel_id and dl_detect_in SHALL be 1, with trace_len, the mask and the timeout counter cleared; the next state SHALL be TRACE.
REQ-023 In TRACE, dl_detect_in SHALL be 1 and origin_vec SHALL be 0.
REQ-024 In TRACE, each cycle deadlock_trace_mask SHALL be ORed with dl_detect_vec and trace_len SHALL increment, saturating at 16'hFFFF.
REQ-025 In TRACE, the trace SHALL close when dl_detect_vec[sel_id]==1 and trace_len>=1: that cycle token_clear SHALL be 1, the mask SHALL include that cycle's bits, and the next state SHALL be REPORT.
REQ-026 In TRACE, when trace_len reaches TRACE_TIMEOUT without closure, the FSM SHALL set trace_timeout, pulse token_clear for one cycle and go to REPORT.
REQ-027 If closure and timeout occur in the same cycle, closure SHALL win and trace_timeout SHALL remain 0.
REQ-028 In REPORT, deadlock_detected SHALL be 1, deadlock_proc_id SHALL be sel_id, and dl_detect_in SHALL stay 1 (freezing the detect units).
REQ-029 All report outputs SHALL hold stable throughout REPORT.
REQ-030 In REPORT, report_ack==1 SHALL move the FSM to IDLE next cycle and clear deadlock_detected, trace_timeout, the mask, trace_len and deadlock_proc_id.
REQ-031 report_ack SHALL be ignored in all states other than REPORT.
REQ-032 origin_vec SHALL always be one-hot or zero, and token_clear SHALL never be asserted in the same cycle as origin_vec.
REQ-033 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-034 Reset SHALL be synchronous: reset==1 at a posedge forces IDLE in any state, including mid-TRACE.
REQ-035 On reset, every output SHALL be 0: dl_detect_in, origin_vec, token_clear, deadlock_detected, deadlock_proc_id, deadlock_trace_mask, trace_len, trace_timeout.
REQ-036 On reset, all internal counters and sel_id SHALL be 0.
REQ-037 Reset asserted mid-TRACE SHALL NOT emit token_clear.

Verification
REQ-038 The bench SHALL check: PROC_NUM=4, DEBOUNCE_CYCLES=4, dl_detect_vec=4'b0100 held for 3 cycles then 0 -> no LAUNCH, origin_vec stays 0, FSM returns to IDLE.
REQ-039 The bench SHALL check: dl_detect_vec=4'b0110 for 4 cycles -> origin_vec=4'b0010 for one cycle, sel_id=1, dl_detect_in=1 from LAUNCH onward.
REQ-040 The bench SHALL check: in TRACE, pulses on bits 2, 3, then 1 one cycle apart -> token_clear on the bit-1 cycle, mask=4'b1110, trace_len=3, deadlock_proc_id=1, deadlock_detected=1 next cycle.
REQ-041 The bench SHALL check: TRACE_TIMEOUT=8 with no return to the origin -> token_clear once at trace_len=8, trace_timeout=1, state REPORT.
REQ-042 The bench SHALL check: report_ack=1 in REPORT -> all report outputs 0 and dl_detect_in=0 next cycle; report_ack in IDLE has no effect.
REQ-043 The bench SHALL check: reset=1 mid-TRACE -> all outputs 0 at the next posedge, no token_clear pulse, and re-detection works after release.

Source files
------------

// File: rtl/pl_kernel_hls_deadlock_report_unit.sv
// pl_kernel_hls_deadlock_report_unit: debounces process deadlock detects, launches a trace token and reports the cycle.
module pl_kernel_hls_deadlock_report_unit #(
    parameter int PROC_NUM        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TRACE_TIMEOUT   = 1024,
    localparam int IW             = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic                report_ack,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                deadlock_detected,
    output logic [IW-1:0]       deadlock_proc_id,
    output logic [PROC_NUM-1:0] deadlock_trace_mask,
    output logic [15:0]         trace_len,
    output logic                trace_timeout
);
    typedef enum logic [2:0] {IDLE, DEBOUNCE, LAUNCH, TRACE, REPORT} state_t;
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [IW-1:0] sel_id, sel_n, low_id;
    logic [15:0] len_inc;
    logic any, deb_done, closure, expire, hold;
    logic dl_in_n, token_n, detected_n, timeout_n;
    logic [PROC_NUM-1:0] origin_n, mask_n;
    logic [IW-1:0] proc_id_n;
    logic [15:0] len_n;
    always_comb begin
        low_id = '0;
        for (int p = PROC_NUM - 1; p >= 0; p--)
            if (dl_detect_vec[p]) low_id = IW'(p);
    end
    assign any      = |dl_detect_vec;
    assign deb_done = (int'(cnt) + 1) >= DEBOUNCE_CYCLES;
    assign len_inc  = (trace_len == 16'hFFFF) ? trace_len : trace_len + 16'd1;
    // The origin's own detect in the first trace cycle is stale, so closure needs at least one hop.
    assign closure  = (state == TRACE) && dl_detect_vec[sel_id] && (trace_len != 16'd0);
    assign expire   = (state == TRACE) && !closure && (int'(len_inc) >= TRACE_TIMEOUT);
    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            sel_id              <= '0;
            dl_detect_in        <= 1'b0;
            origin_vec          <= '0;
            token_clear         <= 1'b0;
            deadlock_detected   <= 1'b0;
            deadlock_proc_id    <= '0;
            deadlock_trace_mask <= '0;
            trace_len           <= '0;
            trace_timeout       <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            sel_id              <= sel_n;
            dl_detect_in        <= dl_in_n;
            origin_vec          <= origin_n;
            token_clear         <= token_n;
            deadlock_detected   <= detected_n;
            deadlock_proc_id    <= proc_id_n;
            deadlock_trace_mask <= mask_n;
            trace_len           <= len_n;
            trace_timeout       <= timeout_n;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (any) state_n = (DEBOUNCE_CYCLES <= 1) ? LAUNCH : DEBOUNCE;
            DEBOUNCE: state_n = !any ? IDLE : deb_done ? LAUNCH : DEBOUNCE;
            LAUNCH:   state_n = TRACE;
            TRACE:    if (closure || expire) state_n = REPORT;
            REPORT:   if (report_ack) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // Outputs are computed one cycle ahead and registered so they line up with the state they describe.
    always_comb begin
        hold       = (state == REPORT) && (state_n == REPORT);
        cnt_n      = (state_n == DEBOUNCE) ? ((state == IDLE) ? 8'd1 : cnt + 8'd1) : 8'd0;
        sel_n      = (state_n == LAUNCH) ? low_id : (state_n == IDLE) ? '0 : sel_id;
        origin_n   = (state_n == LAUNCH) ? PROC_NUM'(1) << sel_n : '0;
        dl_in_n    = (state_n == LAUNCH) || (state_n == TRACE) || (state_n == REPORT);
        token_n    = (state == TRACE) && (state_n == REPORT);
        detected_n = (state_n == REPORT);
        proc_id_n  = (state_n == REPORT) ? sel_id : '0;
        mask_n     = (state == TRACE) ? deadlock_trace_mask | dl_detect_vec : hold ? deadlock_trace_mask : '0;
        len_n      = (state == TRACE) ? len_inc : hold ? trace_len : 16'd0;
        timeout_n  = expire || (hold && trace_timeout);
    end
endmodule

// File: tb/tb_pl_kernel_hls_deadlock_report_unit.sv
// tb_pl_kernel_hls_deadlock_report_unit: directed checks of debounce, launch, trace closure, timeout, ack and reset.
module tb_pl_kernel_hls_deadlock_report_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] vec = '0, vec1 = '0;
    logic ack = 1'b0, ack1 = 1'b0;
    logic dl_in, tclr, det, tmo, dl_in1, tclr1, det1, tmo1;
    logic [3:0] origin, mask, origin1, mask1;
    logic [1:0] pid, pid1;
    logic [15:0] len, len1;
    int errors = 0, checks = 0;
    pl_kernel_hls_deadlock_report_unit #(.PROC_NUM(4), .DEBOUNCE_CYCLES(4), .TRACE_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(vec), .report_ack(ack),
        .dl_detect_in(dl_in), .origin_vec(origin), .token_clear(tclr), .deadlock_detected(det),
        .deadlock_proc_id(pid), .deadlock_trace_mask(mask), .trace_len(len), .trace_timeout(tmo));
    pl_kernel_hls_deadlock_report_unit #(.PROC_NUM(4), .DEBOUNCE_CYCLES(1), .TRACE_TIMEOUT(8)) dut1 (
        .clock(clock), .reset(reset), .dl_detect_vec(vec1), .report_ack(ack1),
        .dl_detect_in(dl_in1), .origin_vec(origin1), .token_clear(tclr1), .deadlock_detected(det1),
        .deadlock_proc_id(pid1), .deadlock_trace_mask(mask1), .trace_len(len1), .trace_timeout(tmo1));
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask
    function automatic logic [31:0] outs();
        return 32'({dl_in, origin, tclr, det, pid, mask, len, tmo});
    endfunction
    initial begin
        tick(2);
        check("reset_outs", outs(), 32'd0);
        reset = 1'b0;
        vec1 = 4'b0100;
        tick();
        check("deb1_origin", 32'(origin1), 32'h4);
        check("deb1_dl_in", 32'(dl_in1), 32'd1);
        vec1 = 4'b0000;
        tick();
        check("deb1_origin_off", 32'(origin1), 32'h0);
        ack = 1'b1;
        tick();
        check("ack_idle", outs(), 32'd0);
        ack = 1'b0;
        vec = 4'b0100;
        tick(3);
        check("short_origin", 32'(origin), 32'h0);
        vec = 4'b0000;
        tick();
        check("short_idle", outs(), 32'd0);
        vec = 4'b0110;
        tick(3);
        check("deb_no_early", 32'(origin), 32'h0);
        tick();
        check("launch_origin", 32'(origin), 32'h2);
        check("launch_dl_in", 32'(dl_in), 32'd1);
        check("launch_no_clr", 32'(tclr), 32'd0);
        vec = 4'b0000;
        tick();
        check("trace_origin", 32'(origin), 32'h0);
        check("trace_dl_in", 32'(dl_in), 32'd1);
        check("trace_len0", 32'(len), 32'd0);
        vec = 4'b0100;
        tick();
        check("hop1_mask", 32'(mask), 32'h4);
        check("hop1_len", 32'(len), 32'd1);
        vec = 4'b1000;
        tick();
        check("hop2_mask", 32'(mask), 32'hC);
        check("hop2_clr", 32'(tclr), 32'd0);
        vec = 4'b0010;
        tick();
        check("close_clr", 32'(tclr), 32'd1);
        check("close_mask", 32'(mask), 32'hE);
        check("close_len", 32'(len), 32'd3);
        check("close_pid", 32'(pid), 32'd1);
        check("close_det", 32'(det), 32'd1);
        check("close_tmo", 32'(tmo), 32'd0);
        vec = 4'b0001;
        tick();
        check("hold_clr", 32'(tclr), 32'd0);
        check("hold_report", outs(), 32'({1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 4'hE, 16'd3, 1'b0}));
        vec = 4'b0000;
        ack = 1'b1;
        tick();
        check("ack_clear", outs(), 32'd0);
        ack = 1'b0;
        vec = 4'b0001;
        tick(4);
        check("to_launch", 32'(origin), 32'h1);
        vec = 4'b0000;
        tick();
        vec = 4'b0100;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_no_clr", 32'(tclr), 32'd0);
        end
        tick();
        check("to_clr", 32'(tclr), 32'd1);
        check("to_report", outs(), 32'({1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 4'h4, 16'd8, 1'b1}));
        tick();
        check("to_clr_once", 32'(tclr), 32'd0);
        check("to_tmo_hold", 32'(tmo), 32'd1);
        vec = 4'b0000;
        ack = 1'b1;
        tick();
        check("to_ack_clear", outs(), 32'd0);
        ack = 1'b0;
        vec = 4'b0001;
        tick(4);
        vec = 4'b0000;
        tick(8);
        vec = 4'b0001;
        tick();
        check("tie_clr", 32'(tclr), 32'd1);
        check("tie_len", 32'(len), 32'd8);
        check("tie_tmo", 32'(tmo), 32'd0);
        check("tie_det", 32'(det), 32'd1);
        vec = 4'b0000;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vec = 4'b1000;
        tick(4);
        check("rst_launch", 32'(origin), 32'h8);
        vec = 4'b0000;
        tick();
        vec = 4'b0100;
        tick();
        check("rst_pre_len", 32'(len), 32'd1);
        reset = 1'b1;
        vec = 4'b1000;
        tick();
        check("rst_mid_trace", outs(), 32'd0);
        reset = 1'b0;
        vec = 4'b0000;
        tick();
        check("rst_after", outs(), 32'd0);
        vec = 4'b0010;
        tick(3);
        check("redet_wait", 32'(origin), 32'h0);
        tick();
        check("redet_origin", 32'(origin), 32'h2);
        check("redet_dl_in", 32'(dl_in), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
